// File: rtl/neuron_seq_ctrl_if.sv
// Job / RAM / neuron / result signal bundle for neuron_seq_ctrl.
// master: scheduler + RAMs + neuron side; slave: the sequencer itself.
interface neuron_seq_ctrl_if #(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned LEN_W    = 11
);
    logic                start;
    logic                abort;
    logic [LEN_W-1:0]    len;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   d_base;
    logic                busy;
    logic                rd_en;
    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_W-1:0]   d_addr;
    logic                mac_clear;
    logic                mac_en;
    logic [BITWIDTH-1:0] accum_in;
    logic [BITWIDTH-1:0] result;
    logic                result_valid;
    logic                result_ready;

    modport master (
        output start, abort, len, w_base, d_base, accum_in, result_ready,
        input  busy, rd_en, w_addr, d_addr, mac_clear, mac_en, result, result_valid
    );

    modport slave (
        input  start, abort, len, w_base, d_base, accum_in, result_ready,
        output busy, rd_en, w_addr, d_addr, mac_clear, mac_en, result, result_valid
    );
endinterface

// File: rtl/neuron_seq_ctrl.sv
// Sequencer for one FP32 MAC neuron: clears the neuron, streams weight/data RAM
// reads (1-cycle read latency), pulses mac_en aligned to returned operands, then
// captures the accumulator and offers it on a valid/ready output.
// Optional build macro NEURON_SEQ_CTRL_RELU_EN: negative-signed accumulators are
// captured as +0.0.
// All outputs are registered; a job started in cycle T shows result_valid at
// T+len+4 for every len, including len=0.
module neuron_seq_ctrl #(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned LEN_W    = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    neuron_seq_ctrl_if.slave     bus_io
);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StRun,
        StDrain,
        StCap,
        StOut
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [ADDR_W-1:0]   d_addr_q, d_addr_d;
    logic                busy_q, busy_d;
    logic                rd_en_q, rd_en_d;
    logic                mac_clear_q, mac_clear_d;
    logic                mac_en_q, mac_en_d;
    logic [BITWIDTH-1:0] result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic [BITWIDTH-1:0] cap_val;

    // Value stored in CAP; a zero-length job always yields +0.0.
    always_comb begin
        cap_val = bus_io.accum_in;
`ifdef NEURON_SEQ_CTRL_RELU_EN
        if (bus_io.accum_in[BITWIDTH-1]) begin
            cap_val = '0;
        end
`endif
        if (len_q == '0) begin
            cap_val = '0;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        w_addr_d       = w_addr_q;
        d_addr_d       = d_addr_q;
        rd_en_d        = 1'b0;
        mac_clear_d    = 1'b0;
        // mac_en is rd_en delayed one stage: operands return a cycle after the read.
        mac_en_d       = rd_en_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    len_d       = bus_io.len;
                    w_addr_d    = bus_io.w_base;
                    d_addr_d    = bus_io.d_base;
                    mac_clear_d = 1'b1;
                    state_d     = StClr;
                end
            end
            StClr: begin
                cnt_d = '0;
                if (len_q == '0) begin
                    // Skip RUN but keep DRAIN so latency stays len+4.
                    state_d = StDrain;
                end else begin
                    rd_en_d = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cnt_q == len_q - LEN_W'(1)) begin
                    state_d = StDrain;
                end else begin
                    cnt_d    = cnt_q + LEN_W'(1);
                    w_addr_d = w_addr_q + ADDR_W'(1);
                    d_addr_d = d_addr_q + ADDR_W'(1);
                    rd_en_d  = 1'b1;
                end
            end
            StDrain: begin
                state_d = StCap;
            end
            StCap: begin
                result_d       = cap_val;
                result_valid_d = 1'b1;
                state_d        = StOut;
            end
            StOut: begin
                if (bus_io.result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort wins over everything, including result_ready.
        if (bus_io.abort && (state_q != StIdle)) begin
            state_d        = StIdle;
            rd_en_d        = 1'b0;
            mac_en_d       = 1'b0;
            result_valid_d = 1'b0;
            // Leave the neuron clean after a cancelled accumulation.
            mac_clear_d    = (state_q != StOut);
        end

        busy_d = (state_d != StIdle);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            len_q          <= '0;
            cnt_q          <= '0;
            w_addr_q       <= '0;
            d_addr_q       <= '0;
            busy_q         <= 1'b0;
            rd_en_q        <= 1'b0;
            mac_clear_q    <= 1'b0;
            mac_en_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            w_addr_q       <= w_addr_d;
            d_addr_q       <= d_addr_d;
            busy_q         <= busy_d;
            rd_en_q        <= rd_en_d;
            mac_clear_q    <= mac_clear_d;
            mac_en_q       <= mac_en_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus_io.busy         = busy_q;
    assign bus_io.rd_en        = rd_en_q;
    assign bus_io.w_addr       = w_addr_q;
    assign bus_io.d_addr       = d_addr_q;
    assign bus_io.mac_clear    = mac_clear_q;
    assign bus_io.mac_en       = mac_en_q;
    assign bus_io.result       = result_q;
    assign bus_io.result_valid = result_valid_q;

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Directed bench for neuron_seq_ctrl with behavioural weight/data RAMs and a
// behavioural FP32 MAC neuron (exact small values only).
module tb_neuron_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    neuron_seq_ctrl_if #(.BITWIDTH(32), .ADDR_W(10), .LEN_W(11)) bus ();

    neuron_seq_ctrl #(.BITWIDTH(32), .ADDR_W(10), .LEN_W(11)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAMs, 1-cycle read latency.
    logic [31:0] wmem [0:1023];
    logic [31:0] dmem [0:1023];
    logic [31:0] w_rd = 32'h0;
    logic [31:0] d_rd = 32'h0;

    always @(posedge clk) begin
        if (bus.rd_en) begin
            w_rd <= wmem[bus.w_addr];
            d_rd <= dmem[bus.d_addr];
        end
    end

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'h0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'h0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        if (b[62:0] == 63'h0) return {b[63], 31'h0};
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    // Behavioural neuron.
    real acc = 0.0;
    always @(posedge clk) begin
        if (bus.mac_clear) acc <= 0.0;
        else if (bus.mac_en) acc <= acc + f2r(w_rd) * f2r(d_rd);
    end
    assign bus.accum_in = r2f(acc);

    logic [9:0] wa [0:15];
    logic [9:0] da [0:15];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a job and follow it until result_valid (or a 40-cycle budget).
    task automatic do_job(input logic [10:0] l, input logic [9:0] wb, input logic [9:0] db,
                          output int n_rd, output int n_mac, output int n_clr,
                          output int lat, output int first_rd, output int first_mac);
        bus.start  = 1'b1;
        bus.len    = l;
        bus.w_base = wb;
        bus.d_base = db;
        tick();
        bus.start = 1'b0;
        n_rd = 0; n_mac = 0; n_clr = 0; lat = -1; first_rd = -1; first_mac = -1;
        for (int c = 1; c <= 40; c++) begin
            if (bus.rd_en) begin
                if (first_rd < 0) first_rd = c;
                if (n_rd < 16) begin
                    wa[n_rd] = bus.w_addr;
                    da[n_rd] = bus.d_addr;
                end
                n_rd++;
            end
            if (bus.mac_en) begin
                if (first_mac < 0) first_mac = c;
                n_mac++;
            end
            if (bus.mac_clear) n_clr++;
            if (bus.result_valid) begin
                lat = c;
                break;
            end
            tick();
        end
    endtask

    task automatic accept();
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
    endtask

    int n_rd, n_mac, n_clr, lat, f_rd, f_mac, cnt;
    logic [31:0] held;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            wmem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
        wmem[10'h10] = 32'h3F800000;
        wmem[10'h11] = 32'h40000000;
        wmem[10'h12] = 32'h40400000;
        wmem[10'h13] = 32'h40800000;
        for (int i = 0; i < 4; i++) dmem[10'h20 + i] = 32'h3F800000;
        wmem[10'h40] = 32'hC0400000;
        dmem[10'h50] = 32'h3F800000;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.len = '0;
        bus.w_base = '0; bus.d_base = '0; bus.result_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_busy", {31'h0, bus.busy}, 32'h0);
        check_eq("rst_rd_en", {31'h0, bus.rd_en}, 32'h0);
        check_eq("rst_mac_clear", {31'h0, bus.mac_clear}, 32'h0);
        check_eq("rst_mac_en", {31'h0, bus.mac_en}, 32'h0);
        check_eq("rst_valid", {31'h0, bus.result_valid}, 32'h0);
        check_eq("rst_w_addr", {22'h0, bus.w_addr}, 32'h0);
        check_eq("rst_result", bus.result, 32'h0);
        rst_n = 1'b1;
        tick();

        // len=4 dot product: 1+2+3+4 = 10.0
        do_job(11'd4, 10'h010, 10'h020, n_rd, n_mac, n_clr, lat, f_rd, f_mac);
        check_eq("j1_n_rd", n_rd, 4);
        check_eq("j1_n_mac", n_mac, 4);
        check_eq("j1_n_clr", n_clr, 1);
        check_eq("j1_first_rd", f_rd, 2);
        check_eq("j1_first_mac", f_mac, 3);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("j1_w_addr%0d", i), {22'h0, wa[i]}, 32'h10 + i);
            check_eq($sformatf("j1_d_addr%0d", i), {22'h0, da[i]}, 32'h20 + i);
        end
        check_eq("j1_latency", lat, 8);
        check_eq("j1_result", bus.result, 32'h41200000);
        check_eq("j1_busy_out", {31'h0, bus.busy}, 32'h1);

        // Hold ready low for 5 cycles while pulsing start.
        held = bus.result;
        for (int i = 0; i < 5; i++) begin
            bus.start  = i[0] ? 1'b0 : 1'b1;
            bus.len    = 11'd2;
            bus.w_base = 10'h040;
            tick();
            check_eq($sformatf("out_valid%0d", i), {31'h0, bus.result_valid}, 32'h1);
            check_eq($sformatf("out_stable%0d", i), bus.result, 32'h41200000);
            check_eq($sformatf("out_no_rd%0d", i), {31'h0, bus.rd_en}, 32'h0);
        end
        bus.start = 1'b0;
        accept();
        check_eq("ready_valid_low", {31'h0, bus.result_valid}, 32'h0);
        check_eq("ready_idle", {31'h0, bus.busy}, 32'h0);
        check_eq("ready_result_kept", bus.result, held);

        // len=0
        do_job(11'd0, 10'h010, 10'h020, n_rd, n_mac, n_clr, lat, f_rd, f_mac);
        check_eq("j0_n_rd", n_rd, 0);
        check_eq("j0_n_mac", n_mac, 0);
        check_eq("j0_n_clr", n_clr, 1);
        check_eq("j0_latency", lat, 4);
        check_eq("j0_result", bus.result, 32'h0);
        accept();

        // Address wrap
        do_job(11'd3, 10'h3FE, 10'h100, n_rd, n_mac, n_clr, lat, f_rd, f_mac);
        check_eq("wrap_n_rd", n_rd, 3);
        check_eq("wrap_w0", {22'h0, wa[0]}, 32'h3FE);
        check_eq("wrap_w1", {22'h0, wa[1]}, 32'h3FF);
        check_eq("wrap_w2", {22'h0, wa[2]}, 32'h000);
        check_eq("wrap_d2", {22'h0, da[2]}, 32'h102);
        check_eq("wrap_latency", lat, 7);
        accept();

        // Abort on the 2nd RUN cycle of a len=8 job.
        bus.start = 1'b1; bus.len = 11'd8; bus.w_base = 10'h010; bus.d_base = 10'h020;
        tick();
        bus.start = 1'b0;
        tick();
        check_eq("ab_run1_rd", {31'h0, bus.rd_en}, 32'h1);
        tick();
        check_eq("ab_run2_addr", {22'h0, bus.w_addr}, 32'h11);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_eq("ab_busy", {31'h0, bus.busy}, 32'h0);
        check_eq("ab_mac_clear", {31'h0, bus.mac_clear}, 32'h1);
        check_eq("ab_rd_en", {31'h0, bus.rd_en}, 32'h0);
        check_eq("ab_mac_en", {31'h0, bus.mac_en}, 32'h0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.result_valid || bus.busy || bus.mac_clear) cnt++;
        end
        check_eq("ab_quiet", cnt, 0);
        do_job(11'd4, 10'h010, 10'h020, n_rd, n_mac, n_clr, lat, f_rd, f_mac);
        check_eq("ab_after_latency", lat, 8);
        check_eq("ab_after_result", bus.result, 32'h41200000);
        accept();

        // Abort in OUT beats result_ready.
        do_job(11'd1, 10'h010, 10'h020, n_rd, n_mac, n_clr, lat, f_rd, f_mac);
        check_eq("ao_latency", lat, 5);
        check_eq("ao_result", bus.result, 32'h3F800000);
        bus.abort = 1'b1;
        bus.result_ready = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.result_ready = 1'b0;
        check_eq("ao_valid", {31'h0, bus.result_valid}, 32'h0);
        check_eq("ao_busy", {31'h0, bus.busy}, 32'h0);
        check_eq("ao_no_clear", {31'h0, bus.mac_clear}, 32'h0);

        // Negative accumulator: raw copy or ReLU clamp.
        do_job(11'd1, 10'h040, 10'h050, n_rd, n_mac, n_clr, lat, f_rd, f_mac);
`ifdef NEURON_SEQ_CTRL_RELU_EN
        check_eq("neg_result", bus.result, 32'h00000000);
`else
        check_eq("neg_result", bus.result, 32'hC0400000);
`endif
        accept();

        // Asynchronous reset mid-RUN.
        bus.start = 1'b1; bus.len = 11'd8; bus.w_base = 10'h010; bus.d_base = 10'h020;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check_eq("ar_pre_rd", {31'h0, bus.rd_en}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_busy", {31'h0, bus.busy}, 32'h0);
        check_eq("ar_rd_en", {31'h0, bus.rd_en}, 32'h0);
        check_eq("ar_mac_en", {31'h0, bus.mac_en}, 32'h0);
        check_eq("ar_w_addr", {22'h0, bus.w_addr}, 32'h0);
        check_eq("ar_d_addr", {22'h0, bus.d_addr}, 32'h0);
        check_eq("ar_result", bus.result, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        do_job(11'd4, 10'h010, 10'h020, n_rd, n_mac, n_clr, lat, f_rd, f_mac);
        check_eq("ar_after_result", bus.result, 32'h41200000);
        accept();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
